// File: rtl/fmap_stream_tx.sv
// fmap_stream_tx: reads one IMG_HEIGHT x IMG_WIDTH frame from a 1-cycle-latency RAM, emits it row-major as a pixel stream.
// Latency: start -> first RAM read 1 cycle later, first valid pixel 3 cycles later; then one pixel per cycle when unstalled.
// Backpressure: reads are throttled so FIFO entries plus the read in flight never exceed 2; output held while stalled.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, base_addr          frame request (taken only in IDLE) and RAM address of pixel (0,0)
//   busy, done                frame in progress / one-cycle completion pulse
//   mem_rd_en, mem_addr       RAM read strobe and address
//   mem_rd_data               RAM data, valid the cycle after mem_rd_en
//   out_ready, valid_out      downstream handshake
//   pix_out, sof, eol, eof    signed pixel plus first-pixel / last-column / last-pixel markers

// Small generic FIFO: registered storage, head visible combinationally, count exported.
// Latency: a push is visible at the head the following cycle.
// Backpressure: none internally; the owner must never push when full or pop when empty.
module fmap_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else begin
      if (push) begin
        store[wr_ptr] <= push_dat;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_dat = store[rd_ptr];
endmodule

module fmap_stream_tx #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int PIX_BITS   = 8,
  parameter int ADDR_BITS  = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_BITS-1:0]        base_addr,
  output logic                        busy,
  output logic                        done,
  output logic                        mem_rd_en,
  output logic [ADDR_BITS-1:0]        mem_addr,
  input  logic [PIX_BITS-1:0]         mem_rd_data,
  input  logic                        out_ready,
  output logic                        valid_out,
  output logic signed [PIX_BITS-1:0]  pix_out,
  output logic                        sof,
  output logic                        eol,
  output logic                        eof
);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int FW    = PIX_BITS + 3;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE_S} state_t;

  state_t               state, state_nxt;
  logic [COL_W-1:0]     rd_col;
  logic [ROW_W-1:0]     rd_row;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 rd_en;
  logic                 inflight;   // a read was issued last cycle; its data is on mem_rd_data now
  logic [2:0]           side_q;     // {sof,eol,eof} of the in-flight read
  logic                 last_rd;
  logic                 pop;
  logic [1:0]           fifo_count;
  logic [FW-1:0]        head;
  logic [2:0]           occ;
  logic                 sof_rd, eol_rd, eof_rd;

  assign eol_rd  = (rd_col == COL_W'(IMG_WIDTH-1));
  assign last_rd = eol_rd && (rd_row == ROW_W'(IMG_HEIGHT-1));
  assign sof_rd  = (rd_col == '0) && (rd_row == '0);
  assign eof_rd  = last_rd;

  assign pop = valid_out && out_ready;
  assign occ = {1'b0, fifo_count} + {2'b00, inflight};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)          state_nxt = STREAM;
      STREAM:  if (rd_en && last_rd) state_nxt = DRAIN;
      DRAIN:   if (pop && eof)     state_nxt = DONE_S;
      DONE_S:                      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Outputs. A read is allowed when the slot it will land in is guaranteed free:
  // entries held + the read in flight, minus the entry leaving this cycle, stays below 2.
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    rd_en = 1'b0;
    case (state)
      STREAM: begin
        busy  = 1'b1;
        rd_en = (occ < (3'd2 + {2'b00, pop}));
      end
      DRAIN:  busy = 1'b1;
      DONE_S: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Read-side address and raster position
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr  <= '0;
      rd_col   <= '0;
      rd_row   <= '0;
      inflight <= 1'b0;
      side_q   <= '0;
    end else begin
      inflight <= rd_en;
      if (state == IDLE && start) begin
        rd_addr <= base_addr;
        rd_col  <= '0;
        rd_row  <= '0;
      end else if (rd_en) begin
        rd_addr <= rd_addr + 1'b1;   // wraps naturally at ADDR_BITS
        side_q  <= {sof_rd, eol_rd, eof_rd};
        if (eol_rd) begin
          rd_col <= '0;
          rd_row <= rd_row + 1'b1;
        end else begin
          rd_col <= rd_col + 1'b1;
        end
      end
    end
  end

  assign mem_rd_en = rd_en;
  assign mem_addr  = rd_addr;

  fmap_fifo #(.WIDTH(FW), .DEPTH(2)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_dat ({side_q, mem_rd_data}),
    .pop      (pop),
    .head_dat (head),
    .count    (fifo_count)
  );

  assign valid_out = (fifo_count != 2'd0);
  assign pix_out   = head[PIX_BITS-1:0];
  assign sof       = head[FW-1];
  assign eol       = head[FW-2];
  assign eof       = head[FW-3];
endmodule
